// File: rtl/tick_ramp_driver_pkg.sv
// rtl/tick_ramp_driver_pkg.sv - shared mode and state encodings for the tick ramp driver
package tick_ramp_driver_pkg;

    // TickRegister write modes; NOP is the only encoding that leaves the register untouched
    typedef enum logic [1:0] {
        MODE_INC = 2'd0,
        MODE_DEC = 2'd1,
        MODE_SET = 2'd2,
        MODE_NOP = 2'd3
    } tick_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_CMP  = 3'd2,
        ST_STEP = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } ramp_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } ramp_dir_e;

    function automatic tick_mode_e step_mode(input ramp_dir_e dir);
        return (dir == DIR_UP) ? MODE_INC : MODE_DEC;
    endfunction

endpackage

// File: rtl/tick_ramp_driver_if.sv
// rtl/tick_ramp_driver_if.sv - command handshake and register-side bus of the ramp driver
interface tick_ramp_driver_if #(
    parameter int SIZE         = 8,
    parameter int PERIOD_WIDTH = 8
);
    logic                    in_cmd_valid;
    logic                    out_cmd_ready;
    logic                    in_cmd_jump;
    logic [SIZE-1:0]         in_target;
    logic [PERIOD_WIDTH-1:0] in_period;
    logic                    in_abort;
    logic [SIZE-1:0]         in_cur;
    logic [1:0]              out_mode;
    logic [SIZE-1:0]         out_val;
    logic                    out_busy;
    logic                    out_done;

    modport slave (
        input  in_cmd_valid, in_cmd_jump, in_target, in_period, in_abort, in_cur,
        output out_cmd_ready, out_mode, out_val, out_busy, out_done
    );

    modport master (
        output in_cmd_valid, in_cmd_jump, in_target, in_period, in_abort, in_cur,
        input  out_cmd_ready, out_mode, out_val, out_busy, out_done
    );
endinterface

// File: rtl/tick_register.sv
// rtl/tick_register.sv - value register updated by INC/DEC/SET/NOP mode commands
module tick_register
    import tick_ramp_driver_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic [1:0]      in_mode,
    input  logic [SIZE-1:0] in_val,
    output logic [SIZE-1:0] out_val
);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_val <= '0;
        end else begin
            case (in_mode)
                MODE_INC: out_val <= out_val + SIZE'(1);
                MODE_DEC: out_val <= out_val - SIZE'(1);
                MODE_SET: out_val <= in_val;
                default:  out_val <= out_val;
            endcase
        end
    end

endmodule

// File: rtl/tick_ramp_driver.sv
// rtl/tick_ramp_driver.sv - drives a TickRegister to a target by direct SET or paced INC/DEC ramp
module tick_ramp_driver
    import tick_ramp_driver_pkg::*;
#(
    parameter int SIZE         = 8,
    parameter int PERIOD_WIDTH = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    tick_ramp_driver_if.slave bus
);

    ramp_state_e             state_q;
    ramp_state_e             state_d;
    logic [SIZE-1:0]         target_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    ramp_dir_e               dir_q;

    tick_mode_e              cnt_mode;
    logic [PERIOD_WIDTH-1:0] cnt_load;
    logic [PERIOD_WIDTH-1:0] cnt_val;

    logic accept;
    assign accept = (state_q == ST_IDLE) && bus.in_cmd_valid;

    // A zero period still needs one WAIT cycle so in_cur settles before the next compare
    assign cnt_load = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;

    tick_register #(
        .SIZE (PERIOD_WIDTH)
    ) u_wait_cnt (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .in_mode (cnt_mode),
        .in_val  (cnt_load),
        .out_val (cnt_val)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            period_q <= '0;
            dir_q    <= DIR_UP;
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q <= bus.in_target;
                period_q <= bus.in_period;
            end
            if (state_q == ST_CMP) begin
                dir_q <= (bus.in_cur < target_q) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_mode = MODE_NOP;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_cmd_valid) begin
                    state_d = bus.in_cmd_jump ? ST_SET : ST_CMP;
                end
            end
            ST_SET: state_d = ST_DONE;
            ST_CMP: begin
                if (bus.in_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.in_cur == target_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cnt_mode = MODE_SET;
                state_d  = bus.in_abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_mode = MODE_DEC;
                if (bus.in_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_val <= PERIOD_WIDTH'(1)) begin
                    state_d = ST_CMP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, so reset silences the register write path at once
    always_comb begin
        bus.out_mode = MODE_NOP;
        bus.out_val  = '0;
        case (state_q)
            ST_SET: begin
                bus.out_mode = MODE_SET;
                bus.out_val  = target_q;
            end
            ST_STEP: bus.out_mode = step_mode(dir_q);
            default: bus.out_mode = MODE_NOP;
        endcase
    end

    assign bus.out_cmd_ready = (state_q == ST_IDLE);
    assign bus.out_busy      = (state_q != ST_IDLE);
    assign bus.out_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_tick_ramp_driver.sv
// tb/tb_tick_ramp_driver.sv - self-checking bench for tick_ramp_driver
module tb_tick_ramp_driver;
    import tick_ramp_driver_pkg::*;

    logic clk;
    logic rst;
    logic       load_en;
    logic [7:0] load_val;
    logic [7:0] cur;
    int n_cmp;
    int n_bad;

    tick_ramp_driver_if #(.SIZE(8), .PERIOD_WIDTH(8)) bus ();

    tick_ramp_driver #(.SIZE(8), .PERIOD_WIDTH(8)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural TickRegister being driven; the bench can preload it while the driver idles
    always @(posedge clk) begin
        if (load_en) begin
            cur <= load_val;
        end else begin
            case (bus.out_mode)
                2'd0:    cur <= cur + 8'd1;
                2'd1:    cur <= cur - 8'd1;
                2'd2:    cur <= bus.out_val;
                default: cur <= cur;
            endcase
        end
    end
    assign bus.in_cur = cur;

    typedef struct {
        logic jump;
        int   start;
        int   target;
        int   period;
        int   exp_done;
        int   exp_writes;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int model_done(input logic jump, input int start, input int target, input int period);
        int n;
        int pe;
        n  = (start > target) ? start - target : target - start;
        pe = (period == 0) ? 1 : period;
        return jump ? 2 : n * (pe + 2) + 2;
    endfunction

    function automatic int model_writes(input logic jump, input int start, input int target);
        return jump ? 1 : ((start > target) ? start - target : target - start);
    endfunction

    task automatic preset(input int v);
        load_val = v[7:0];
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Presents one command at a negedge; returns at the negedge of cycle 1
    task automatic start_cmd(input logic jump, input int target, input int period);
        bus.in_cmd_valid = 1'b1;
        bus.in_cmd_jump  = jump;
        bus.in_target    = target[7:0];
        bus.in_period    = period[7:0];
        @(negedge clk);
        bus.in_cmd_valid = 1'b0;
        bus.in_target    = 8'($urandom);
        bus.in_period    = 8'($urandom);
    endtask

    task automatic run_cmd(input string name, input logic jump, input int start, input int target,
                           input int period, input int exp_done, input int exp_writes);
        int c;
        int dcyc;
        int writes;
        int bad;
        int pe;
        logic [1:0] dmode;
        pe    = (period == 0) ? 1 : period;
        dmode = (start < target) ? MODE_INC : MODE_DEC;
        preset(start);
        check({name, " ready_idle"}, int'(bus.out_cmd_ready), 1);
        start_cmd(jump, target, period);
        c = 1; dcyc = 0; writes = 0; bad = 0;
        while (dcyc == 0 && c <= exp_done + 20) begin
            if (!bus.out_busy) bad++;
            if (bus.out_mode != MODE_SET && bus.out_val != 8'd0) bad++;
            if (bus.out_mode != MODE_NOP) begin
                writes++;
                if (jump) begin
                    if (bus.out_mode != MODE_SET || int'(bus.out_val) != target || c != 1) bad++;
                end else begin
                    if (bus.out_mode != dmode || c < 2 || ((c - 2) % (pe + 2)) != 0) bad++;
                end
            end
            if (bus.out_done) dcyc = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check({name, " done_cycle"}, dcyc, exp_done);
        check({name, " writes"}, writes, exp_writes);
        check({name, " bad_cycles"}, bad, 0);
        @(negedge clk);
        check({name, " ready_after"}, int'(bus.out_cmd_ready && !bus.out_busy && !bus.out_done), 1);
        check({name, " final_cur"}, int'(cur), target);
    endtask

    initial begin
        int c;
        int cnt;
        int dcyc;
        n_cmp = 0;
        n_bad = 0;
        load_en = 1'b0;
        load_val = 8'd0;
        bus.in_cmd_valid = 1'b0;
        bus.in_cmd_jump  = 1'b0;
        bus.in_target    = 8'd0;
        bus.in_period    = 8'd0;
        bus.in_abort     = 1'b0;
        rst = 1'b1;
        #1;
        check("reset mode", int'(bus.out_mode), int'(MODE_NOP));
        check("reset val", int'(bus.out_val), 0);
        check("reset ready", int'(bus.out_cmd_ready), 1);
        check("reset busy", int'(bus.out_busy), 0);
        check("reset done", int'(bus.out_done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{1'b1, 10, 200, 4, 2, 1};
        tbl[1] = '{1'b0, 3, 5, 1, 8, 2};
        tbl[2] = '{1'b0, 3, 5, 0, 8, 2};
        tbl[3] = '{1'b0, 255, 0, 3, 1277, 255};
        tbl[4] = '{1'b0, 42, 42, 5, 2, 0};
        tbl[5] = '{1'b0, 100, 97, 2, 14, 3};
        tbl[6] = '{1'b1, 42, 42, 0, 2, 1};
        for (int i = 0; i < 7; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].jump, tbl[i].start, tbl[i].target,
                    tbl[i].period, tbl[i].exp_done, tbl[i].exp_writes);
        end

        for (int i = 0; i < 24; i++) begin
            logic j;
            int s;
            int t;
            int p;
            j = ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 255);
            t = s + $urandom_range(0, 30) - 15;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            p = $urandom_range(0, 6);
            run_cmd($sformatf("rnd%0d", i), j, s, t, p, model_done(j, s, t, p), model_writes(j, s, t));
        end

        // Reset in the middle of WAIT
        preset(0);
        start_cmd(1'b0, 10, 6);
        @(negedge clk);
        check("rst_wait inc", int'(bus.out_mode), int'(MODE_INC));
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_wait mode", int'(bus.out_mode), int'(MODE_NOP));
        check("rst_wait busy", int'(bus.out_busy), 0);
        check("rst_wait ready", int'(bus.out_cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_done || bus.out_mode != MODE_NOP) cnt++;
            @(negedge clk);
        end
        check("rst_wait quiet", cnt, 0);
        check("rst_wait cur", int'(cur), 1);

        // Abort in WAIT after two INCs
        preset(50);
        start_cmd(1'b0, 60, 3);
        repeat (7) @(negedge clk);
        bus.in_abort = 1'b1;
        @(negedge clk);
        bus.in_abort = 1'b0;
        check("abort busy", int'(bus.out_busy), 0);
        check("abort ready", int'(bus.out_cmd_ready), 1);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.out_done || bus.out_mode != MODE_NOP) cnt++;
            @(negedge clk);
        end
        check("abort quiet", cnt, 0);
        check("abort cur", int'(cur), 52);

        // Commands presented while busy are ignored
        preset(20);
        start_cmd(1'b0, 23, 1);
        bus.in_cmd_valid = 1'b1;
        bus.in_cmd_jump  = 1'b1;
        bus.in_target    = 8'd0;
        c = 1; cnt = 0; dcyc = 0;
        while (dcyc == 0 && c < 40) begin
            if (bus.out_cmd_ready) cnt++;
            if (bus.out_done) begin
                dcyc = c;
                bus.in_cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        bus.in_cmd_valid = 1'b0;
        check("busy_valid done_cycle", dcyc, 11);
        check("busy_valid ready_seen", cnt, 0);
        @(negedge clk);
        check("busy_valid idle", int'(bus.out_busy), 0);
        check("busy_valid cur", int'(cur), 23);

        // Abort coincident with a command in IDLE; abort also ignored in SET and DONE
        preset(5);
        bus.in_abort = 1'b1;
        start_cmd(1'b1, 77, 0);
        check("abort_idle set", int'(bus.out_mode), int'(MODE_SET));
        check("abort_idle val", int'(bus.out_val), 77);
        @(negedge clk);
        check("abort_idle done", int'(bus.out_done), 1);
        bus.in_abort = 1'b0;
        @(negedge clk);
        check("abort_idle ready", int'(bus.out_cmd_ready), 1);
        check("abort_idle cur", int'(cur), 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
